// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan driver.
//   DIGITS     : number of display digits scanned
//   SEG_BLANK  : segment pattern with every segment dark (active-low)
//   AN_OFF     : anode pattern with every digit disabled (active-low)
//   hex_to_seg : 4-bit value -> active-low {g,f,e,d,c,b,a} pattern
package seg_pkg;

  localparam int          DIGITS    = 8;
  localparam logic [6:0]  SEG_BLANK = 7'h7F;
  localparam logic [7:0]  AN_OFF    = 8'hFF;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational hex digit decoder for an active-low 7-segment display.
// Ports:
//   nibble in  4  hex value to show
//   seg    out 7  segments {g,f,e,d,c,b,a}, active-low
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode 7-segment display.
// One digit is lit per refresh tick; the displayed word is latched once per
// frame (on the digit 7 -> 0 wrap) so a frame never mixes two words.
// All pin outputs are registered, one clock behind the scan state.
// Ports:
//   clk      in  1   system clock, rising edge
//   rst_n    in  1   asynchronous active-low reset
//   value    in  32  word to show; digit k shows value[4k+3:4k]
//   blank_lz in  1   1 = blank leading-zero digits (digit 0 never blanked)
//   dp_mask  in  8   bit k lights the decimal point of digit k
//   an       out 8   digit enables, active-low, one-hot-low while scanning
//   seg      out 7   segments {g,f,e,d,c,b,a}, active-low
//   dp       out 1   decimal point, active-low
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] value,
  input  logic        blank_lz,
  input  logic [7:0]  dp_mask,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int             CW       = $clog2(SCAN_DIV);
  localparam int             IW       = $clog2(DIGITS);
  localparam logic [CW-1:0]  DIV_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]  IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0] div_cnt;
  logic [IW-1:0] idx;
  logic [31:0]   snap;
  logic          tick;

  logic [3:0]    cur_nib;
  logic [31:0]   upper;
  logic          blank;
  logic [6:0]    hex_seg;

  assign tick = (div_cnt == DIV_LAST);

  // Prescaler, digit index and frame latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      idx     <= '0;
      snap    <= '0;
    end else begin
      if (tick) begin
        div_cnt <= '0;
        idx     <= idx + IW'(1);
        if (idx == IDX_LAST) begin
          snap <= value;
        end
      end else begin
        div_cnt <= div_cnt + CW'(1);
      end
    end
  end

  // The current nibble and everything above it; the digit is a leading
  // zero when that upper slice (including itself) is all zero.
  assign cur_nib = snap[{idx, 2'b00} +: 4];
  assign upper   = snap >> {idx, 2'b00};
  assign blank   = blank_lz && (idx != '0) && (upper == 32'd0);

  hex7seg u_hex7seg (
    .nibble (cur_nib),
    .seg    (hex_seg)
  );

  // Registered pin stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= ~(DIGITS'(1) << idx);
      seg <= blank ? SEG_BLANK : hex_seg;
      dp  <= ~dp_mask[idx];
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver with SCAN_DIV=4 (32-cycle frame).
// Outputs are sampled 1 time unit after each rising edge. cyc counts edges
// since the last reset release; the word is latched on edges where
// cyc % 32 == 0 and appears from the following edge (digit 0).
module tb_seg_scan_driver;

  logic        clk;
  logic        rst_n;
  logic [31:0] value;
  logic        blank_lz;
  logic [7:0]  dp_mask;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int          n_cmp;
  int          n_err;
  int          cyc;

  logic [15:0] exp_q[$];
  logic [6:0]  hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg_scan_driver #(.SCAN_DIV(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value    (value),
    .blank_lz (blank_lz),
    .dp_mask  (dp_mask),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Advance through the next latch edge so the following frame shows the
  // currently driven value.
  task automatic align_frame;
    do step(); while (cyc % 32 != 0);
  endtask

  function automatic logic [15:0] pack_exp(input int d, input logic [6:0] s, input logic p);
    logic [7:0] a;
    a = ~(8'd1 << d);
    return {a, s, p};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_n    = 1'b0;
    value    = 32'h12345678;
    blank_lz = 1'b0;
    dp_mask  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (an !== 8'hFF) begin n_err++; $display("FAIL reset_an got=%h exp=ff", an); end
    n_cmp++;
    if (seg !== 7'h7F) begin n_err++; $display("FAIL reset_seg got=%h exp=7f", seg); end
    n_cmp++;
    if (dp !== 1'b1) begin n_err++; $display("FAIL reset_dp got=%b exp=1", dp); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    step();
    n_cmp++;
    if (an !== 8'hFE) begin n_err++; $display("FAIL first_an got=%h exp=fe", an); end
    n_cmp++;
    if (seg !== 7'h40) begin n_err++; $display("FAIL first_seg got=%h exp=40", seg); end
    n_cmp++;
    if (dp !== 1'b1) begin n_err++; $display("FAIL first_dp got=%b exp=1", dp); end
  endtask

  task automatic test_digits;
    logic [15:0] got, exp;
    align_frame();
    for (int d = 0; d < 8; d++)
      repeat (4) exp_q.push_back(pack_exp(d, hex_tab[value[4*d +: 4]], 1'b1));
    for (int i = 0; i < 32; i++) begin
      step();
      got = {an, seg, dp};
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL digits cyc=%0d got an=%h seg=%h dp=%b exp an=%h seg=%h dp=%b",
                 cyc, got[15:8], got[7:1], got[0], exp[15:8], exp[7:1], exp[0]);
      end
    end
  endtask

  task automatic test_tearing;
    logic [15:0] got, exp;
    logic [31:0] old_v;
    old_v = 32'h12345678;
    value = old_v;
    align_frame();
    for (int d = 0; d < 8; d++)
      repeat (4) exp_q.push_back(pack_exp(d, hex_tab[old_v[4*d +: 4]], 1'b1));
    for (int d = 0; d < 8; d++)
      repeat (4) exp_q.push_back(pack_exp(d, 7'h0E, 1'b1));
    for (int i = 0; i < 64; i++) begin
      step();
      if (i == 13) value = 32'hFFFFFFFF;  // scan state is at digit 3 here
      got = {an, seg, dp};
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL tearing cyc=%0d got an=%h seg=%h dp=%b exp an=%h seg=%h dp=%b",
                 cyc, got[15:8], got[7:1], got[0], exp[15:8], exp[7:1], exp[0]);
      end
    end
  endtask

  task automatic test_blank;
    logic [15:0] got, exp;
    logic [6:0]  s;
    blank_lz = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      value = (pass == 0) ? 32'h000000A5 : 32'h00000000;
      align_frame();
      for (int d = 0; d < 8; d++) begin
        if (pass == 0) s = (d == 0) ? 7'h12 : (d == 1) ? 7'h08 : 7'h7F;
        else           s = (d == 0) ? 7'h40 : 7'h7F;
        repeat (4) exp_q.push_back(pack_exp(d, s, 1'b1));
      end
      for (int i = 0; i < 32; i++) begin
        step();
        got = {an, seg, dp};
        exp = exp_q.pop_front();
        n_cmp++;
        if (got !== exp) begin
          n_err++;
          $display("FAIL blank%0d cyc=%0d got an=%h seg=%h dp=%b exp an=%h seg=%h dp=%b",
                   pass, cyc, got[15:8], got[7:1], got[0], exp[15:8], exp[7:1], exp[0]);
        end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_dp;
    logic [15:0] got, exp;
    value   = $urandom_range(32'h7FFFFFFF, 32'h10000000);
    dp_mask = 8'h04;
    align_frame();
    for (int d = 0; d < 8; d++)
      repeat (4) exp_q.push_back(pack_exp(d, hex_tab[value[4*d +: 4]], (d == 2) ? 1'b0 : 1'b1));
    for (int i = 0; i < 32; i++) begin
      step();
      got = {an, seg, dp};
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL dp cyc=%0d got an=%h seg=%h dp=%b exp an=%h seg=%h dp=%b",
                 cyc, got[15:8], got[7:1], got[0], exp[15:8], exp[7:1], exp[0]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] got, exp;
    repeat (21) step();   // state now at digit 5 (cyc % 32 == 21)
    #2;
    rst_n = 1'b0;
    #1;
    got = {an, seg, dp};
    n_cmp++;
    if (got !== {8'hFF, 7'h7F, 1'b1}) begin
      n_err++;
      $display("FAIL mid_reset got an=%h seg=%h dp=%b exp an=ff seg=7f dp=1",
               got[15:8], got[7:1], got[0]);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    // snap is back to 0, so the first frame shows 0 on every digit
    for (int d = 0; d < 8; d++)
      repeat (4) exp_q.push_back(pack_exp(d, 7'h40, (d == 2) ? 1'b0 : 1'b1));
    for (int i = 0; i < 32; i++) begin
      step();
      got = {an, seg, dp};
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL restart cyc=%0d got an=%h seg=%h dp=%b exp an=%h seg=%h dp=%b",
                 cyc, got[15:8], got[7:1], got[0], exp[15:8], exp[7:1], exp[0]);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    test_reset();
    test_digits();
    test_tearing();
    test_blank();
    test_dp();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
